// File: rtl/hazard_stall_unit.sv
// Hazard detection and stall control for the ID stage.
// Compares ID source addresses against the ID/EX and EX/MEM destination slots
// using T_use/T_new timing, adds a mult/div structural hazard, and drives the
// PC / IF/ID enables and the ID/EX bubble. Also keeps the mult/div busy
// counter and a free-running count of stalled cycles.
module hazard_stall_unit #(
  parameter int unsigned URA_W       = 7,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [URA_W-1:0] rs_URA_D,
  input  logic [URA_W-1:0] rt_URA_D,
  input  logic [1:0]       T_use_rs_D,
  input  logic [1:0]       T_use_rt_D,
  input  logic             md_use_D,
  input  logic [URA_W-1:0] rd_URA_1_E,
  input  logic [URA_W-1:0] rd_URA_2_E,
  input  logic [URA_W-1:0] rd_URA_3_E,
  input  logic [1:0]       T_new_E,
  input  logic [URA_W-1:0] rd_URA_1_M,
  input  logic [URA_W-1:0] rd_URA_2_M,
  input  logic [URA_W-1:0] rd_URA_3_M,
  input  logic [1:0]       T_new_M,
  input  logic             md_start_E,
  input  logic             md_is_div_E,
  output logic             pc_enable,
  output logic             IF_ID_enable,
  output logic             ID_EX_bubble,
  output logic             md_busy,
  output logic [31:0]      stall_count
);

  // The counter must hold whichever of the two latencies is longer.
  localparam int unsigned CNT_MAX = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  // A source is hazardous against a stage when it names a real register that
  // one of the stage's destination slots writes, and the value is needed
  // before that stage can produce it. src != 0 also keeps zero slots inert.
  function automatic logic src_hazard(
    input logic [URA_W-1:0] src,
    input logic [1:0]       t_use,
    input logic [URA_W-1:0] rd1,
    input logic [URA_W-1:0] rd2,
    input logic [URA_W-1:0] rd3,
    input logic [1:0]       t_new
  );
    logic hit;
    hit = (src == rd1) || (src == rd2) || (src == rd3);
    return (src != '0) && hit && (t_use < t_new);
  endfunction

  logic [CNT_W-1:0] r_md_cnt;
  logic [31:0]      r_stall_count;

  logic w_haz_rs_E;
  logic w_haz_rt_E;
  logic w_haz_rs_M;
  logic w_haz_rt_M;
  logic w_data_haz;
  logic w_md_haz;
  logic w_stall;

  assign md_busy     = (r_md_cnt != '0);
  assign stall_count = r_stall_count;

  // Data and mult/div hazard evaluation for the instruction currently in ID.
  always_comb begin
    w_haz_rs_E = src_hazard(rs_URA_D, T_use_rs_D, rd_URA_1_E, rd_URA_2_E, rd_URA_3_E, T_new_E);
    w_haz_rt_E = src_hazard(rt_URA_D, T_use_rt_D, rd_URA_1_E, rd_URA_2_E, rd_URA_3_E, T_new_E);
    w_haz_rs_M = src_hazard(rs_URA_D, T_use_rs_D, rd_URA_1_M, rd_URA_2_M, rd_URA_3_M, T_new_M);
    w_haz_rt_M = src_hazard(rt_URA_D, T_use_rt_D, rd_URA_1_M, rd_URA_2_M, rd_URA_3_M, T_new_M);
    w_data_haz = w_haz_rs_E | w_haz_rt_E | w_haz_rs_M | w_haz_rt_M;
    // md_start_E covers the issue cycle, before the counter has loaded.
    w_md_haz   = md_use_D & (md_busy | md_start_E);
    w_stall    = w_data_haz | w_md_haz;
  end

  // Freeze the front end and inject a bubble while stalled.
  always_comb begin
    pc_enable    = ~w_stall;
    IF_ID_enable = ~w_stall;
    ID_EX_bubble = w_stall;
  end

  // Mult/div busy counter: load on issue, otherwise count down to zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_md_cnt <= '0;
    end else if (md_start_E) begin
      r_md_cnt <= md_is_div_E ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    end else if (r_md_cnt != '0) begin
      r_md_cnt <= r_md_cnt - CNT_W'(1);
    end
  end

  // Debug count of stalled cycles; wraps naturally at 32 bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_count <= '0;
    end else if (w_stall) begin
      r_stall_count <= r_stall_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Self-checking bench for hazard_stall_unit: directed scenarios followed by
// randomized traffic, all compared against a rule-level reference model.
module tb_hazard_stall_unit;

  localparam int URA_W = 7;
  localparam int MULT_N = 5;
  localparam int DIV_N = 10;

  logic             clk = 1'b0;
  logic             reset;
  logic [URA_W-1:0] rs_URA_D, rt_URA_D;
  logic [1:0]       T_use_rs_D, T_use_rt_D;
  logic             md_use_D;
  logic [URA_W-1:0] rd_URA_1_E, rd_URA_2_E, rd_URA_3_E;
  logic [1:0]       T_new_E;
  logic [URA_W-1:0] rd_URA_1_M, rd_URA_2_M, rd_URA_3_M;
  logic [1:0]       T_new_M;
  logic             md_start_E, md_is_div_E;
  logic             pc_enable, IF_ID_enable, ID_EX_bubble, md_busy;
  logic [31:0]      stall_count;

  hazard_stall_unit #(.URA_W(URA_W), .MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset),
    .rs_URA_D(rs_URA_D), .rt_URA_D(rt_URA_D),
    .T_use_rs_D(T_use_rs_D), .T_use_rt_D(T_use_rt_D), .md_use_D(md_use_D),
    .rd_URA_1_E(rd_URA_1_E), .rd_URA_2_E(rd_URA_2_E), .rd_URA_3_E(rd_URA_3_E), .T_new_E(T_new_E),
    .rd_URA_1_M(rd_URA_1_M), .rd_URA_2_M(rd_URA_2_M), .rd_URA_3_M(rd_URA_3_M), .T_new_M(T_new_M),
    .md_start_E(md_start_E), .md_is_div_E(md_is_div_E),
    .pc_enable(pc_enable), .IF_ID_enable(IF_ID_enable), .ID_EX_bubble(ID_EX_bubble),
    .md_busy(md_busy), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference model: busy is "fewer than len edges have passed since the issue edge".
  longint    k = 0;
  longint    start_k = 0;
  int        start_len = 0;
  bit        started = 1'b0;
  bit [31:0] m_cnt = 0;

  function automatic bit m_busy();
    return started && ((k - start_k) < longint'(start_len));
  endfunction

  function automatic bit m_stall();
    bit h;
    logic [URA_W-1:0] src;
    logic [1:0] tu;
    logic [URA_W-1:0] e_addr [3];
    logic [URA_W-1:0] m_addr [3];
    h = 1'b0;
    e_addr[0] = rd_URA_1_E; e_addr[1] = rd_URA_2_E; e_addr[2] = rd_URA_3_E;
    m_addr[0] = rd_URA_1_M; m_addr[1] = rd_URA_2_M; m_addr[2] = rd_URA_3_M;
    for (int s = 0; s < 2; s++) begin
      src = (s == 0) ? rs_URA_D : rt_URA_D;
      tu  = (s == 0) ? T_use_rs_D : T_use_rt_D;
      if (src != 0) begin
        for (int j = 0; j < 3; j++) begin
          if (e_addr[j] == src && int'(tu) < int'(T_new_E)) h = 1'b1;
          if (m_addr[j] == src && int'(tu) < int'(T_new_M)) h = 1'b1;
        end
      end
    end
    if (md_use_D && (m_busy() || md_start_E)) h = 1'b1;
    return h;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    rs_URA_D = 0; rt_URA_D = 0; T_use_rs_D = 2'd3; T_use_rt_D = 2'd3; md_use_D = 0;
    rd_URA_1_E = 0; rd_URA_2_E = 0; rd_URA_3_E = 0; T_new_E = 0;
    rd_URA_1_M = 0; rd_URA_2_M = 0; rd_URA_3_M = 0; T_new_M = 0;
    md_start_E = 0; md_is_div_E = 0;
  endtask

  // Inputs are already set (after a negedge). Check, clock, advance model.
  task automatic step(input string tag);
    bit st;
    #1;
    st = m_stall();
    chk({tag, ".pc_en"}, {31'd0, pc_enable}, {31'd0, ~st});
    chk({tag, ".ifid_en"}, {31'd0, IF_ID_enable}, {31'd0, ~st});
    chk({tag, ".bubble"}, {31'd0, ID_EX_bubble}, {31'd0, st});
    chk({tag, ".busy"}, {31'd0, md_busy}, {31'd0, m_busy()});
    chk({tag, ".scount"}, stall_count, m_cnt);
    @(posedge clk);
    k++;
    if (reset) begin
      started = 1'b0;
      m_cnt = 0;
    end else begin
      if (st) m_cnt = m_cnt + 1;
      if (md_start_E) begin
        started = 1'b1;
        start_k = k;
        start_len = md_is_div_E ? DIV_N : MULT_N;
      end
    end
    @(negedge clk);
  endtask

  function automatic logic [URA_W-1:0] rand_addr();
    logic [URA_W-1:0] a;
    a = URA_W'($urandom_range(0, 3));
    if ($urandom_range(0, 4) == 0) a = a | 7'h40;
    return a;
  endfunction

  int busy_seen;
  bit [31:0] base;

  initial begin
    reset = 1'b1;
    clear_inputs();
    @(negedge clk);
    step("rst0");
    step("rst1");
    reset = 1'b0;
    step("idle");
    chk("reset_scount", stall_count, 32'd0);

    // Load-use then forwarding from MEM.
    rd_URA_1_E = 5; T_new_E = 2; rs_URA_D = 5; T_use_rs_D = 0;
    step("lu_E");
    rd_URA_1_E = 0; T_new_E = 0; rd_URA_1_M = 5; T_new_M = 1;
    step("lu_M");
    T_new_M = 0;
    step("lu_done");
    chk("lu_count", stall_count, 32'd2);

    // Forwardable and zero-address cases.
    clear_inputs();
    rd_URA_2_M = 9; T_new_M = 1; rt_URA_D = 9; T_use_rt_D = 1;
    step("fwd");
    rt_URA_D = 0; rd_URA_2_M = 0;
    step("zero");
    // Full-width compare: 0x49 must not match 0x09.
    rd_URA_2_M = 7'h49; rt_URA_D = 7'h09; T_use_rt_D = 0;
    step("width");
    chk("fwd_count", stall_count, 32'd2);

    // Divide with a mult/div consumer waiting in ID.
    clear_inputs();
    md_use_D = 1; md_start_E = 1; md_is_div_E = 1;
    step("div_start");
    md_start_E = 0; md_is_div_E = 0;
    busy_seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (md_busy) busy_seen++;
      step("div_wait");
    end
    chk("div_busy_len", busy_seen, DIV_N);
    chk("div_stalls", stall_count, 32'd13);

    // Multiply with no consumer: busy but never stalls.
    md_use_D = 0; md_start_E = 1;
    base = stall_count;
    step("mul_start");
    md_start_E = 0;
    busy_seen = 0;
    for (int i = 0; i < 7; i++) begin
      if (md_busy) busy_seen++;
      step("mul_wait");
    end
    chk("mul_busy_len", busy_seen, MULT_N);
    chk("mul_nostall", stall_count, base);

    // Reset three cycles into a divide.
    md_use_D = 1; md_start_E = 1; md_is_div_E = 1;
    step("rd_start");
    md_start_E = 0; md_is_div_E = 0;
    step("rd_w1");
    step("rd_w2");
    reset = 1'b1;
    step("rd_reset");
    reset = 1'b0;
    #1;
    chk("rd_busy", {31'd0, md_busy}, 32'd0);
    chk("rd_count", stall_count, 32'd0);
    chk("rd_nostall", {31'd0, ID_EX_bubble}, 32'd0);
    step("rd_after");

    // Wrap of the stall counter.
    clear_inputs();
    force dut.r_stall_count = 32'hFFFF_FFFF;
    release dut.r_stall_count;
    m_cnt = 32'hFFFF_FFFF;
    rd_URA_3_E = 7'h7F; T_new_E = 3; rt_URA_D = 7'h7F; T_use_rt_D = 2;
    step("wrap");
    clear_inputs();
    step("wrap_after");
    chk("wrap_zero", stall_count, 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      rs_URA_D = rand_addr(); rt_URA_D = rand_addr();
      T_use_rs_D = 2'($urandom_range(0, 3)); T_use_rt_D = 2'($urandom_range(0, 3));
      md_use_D = ($urandom_range(0, 2) == 0);
      rd_URA_1_E = rand_addr(); rd_URA_2_E = rand_addr(); rd_URA_3_E = rand_addr();
      T_new_E = 2'($urandom_range(0, 3));
      rd_URA_1_M = rand_addr(); rd_URA_2_M = rand_addr(); rd_URA_3_M = rand_addr();
      T_new_M = 2'($urandom_range(0, 3));
      md_start_E = ($urandom_range(0, 7) == 0);
      md_is_div_E = 1'($urandom_range(0, 1));
      reset = ($urandom_range(0, 49) == 0);
      step("rand");
    end
    reset = 1'b0;
    clear_inputs();
    step("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
